// File: rtl/char_collect_if.sv
// Character-interface bundle: match stream in, packed per-plate result out.
interface char_collect_if #(
  parameter int N_CHAR = 7,
  parameter int IDX_W  = 4,
  parameter int DIFF_W = 16
);
  logic                     frame_start;
  logic                     frame_end;
  logic                     match_valid;
  logic [2:0]               match_slot;
  logic [IDX_W-1:0]         match_tmpl;
  logic [DIFF_W-1:0]        match_diff;
  logic [N_CHAR*IDX_W-1:0]  char_index_c;
  logic [N_CHAR*DIFF_W-1:0] char_diff_c;
  logic                     char_valid_c;
  logic                     busy;
  logic [7:0]               frame_cnt;
  logic                     proto_err;

  modport master (
    output frame_start, frame_end, match_valid, match_slot, match_tmpl, match_diff,
    input  char_index_c, char_diff_c, char_valid_c, busy, frame_cnt, proto_err
  );

  modport slave (
    input  frame_start, frame_end, match_valid, match_slot, match_tmpl, match_diff,
    output char_index_c, char_diff_c, char_valid_c, busy, frame_cnt, proto_err
  );
endinterface

// File: rtl/char_collect.sv
// Per-plate character collector: keeps the lowest-diff template per slot over
// one frame and emits the packed result with a one-cycle valid pulse.
module char_collect #(
  parameter int N_CHAR = 7,
  parameter int IDX_W  = 4,
  parameter int DIFF_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  char_collect_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0]         best_idx   [N_CHAR];
  logic [DIFF_W-1:0]        best_diff  [N_CHAR];
  logic [IDX_W-1:0]         merged_idx [N_CHAR];
  logic [DIFF_W-1:0]        merged_diff[N_CHAR];
  logic [N_CHAR*IDX_W-1:0]  packed_idx;
  logic [N_CHAR*DIFF_W-1:0] packed_diff;

  logic slot_ok;
  logic take;
  logic do_init;
  logic emit_go;
  logic err_evt;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and control decode; frame_start outranks frame_end in ACCUM.
  always_comb begin
    state_nxt = state;
    do_init   = 1'b0;
    emit_go   = 1'b0;
    err_evt   = 1'b0;
    slot_ok   = int'(bus.match_slot) < N_CHAR;
    unique case (state)
      IDLE: begin
        err_evt = bus.match_valid | bus.frame_end;
        if (bus.frame_start) begin
          do_init   = 1'b1;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        err_evt = bus.frame_start | (bus.match_valid & ~slot_ok);
        if (bus.frame_start) begin
          do_init = 1'b1;
        end else if (bus.frame_end) begin
          emit_go   = 1'b1;
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        err_evt   = bus.frame_start | bus.match_valid;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Best-so-far merged with this cycle's match so a match in the frame_end cycle is emitted.
  always_comb begin
    take = (state == ACCUM) && bus.match_valid && slot_ok &&
           (bus.match_diff < best_diff[bus.match_slot]);
    for (int unsigned k = 0; k < N_CHAR; k++) begin
      merged_idx[k]  = best_idx[k];
      merged_diff[k] = best_diff[k];
      if (take && (bus.match_slot == 3'(k))) begin
        merged_idx[k]  = bus.match_tmpl;
        merged_diff[k] = bus.match_diff;
      end
    end
  end

  // Pack slots with slot 0 in the most significant field.
  always_comb begin
    packed_idx  = '0;
    packed_diff = '0;
    for (int unsigned k = 0; k < N_CHAR; k++) begin
      packed_idx[(N_CHAR-k)*IDX_W-1 -: IDX_W]    = merged_idx[k];
      packed_diff[(N_CHAR-k)*DIFF_W-1 -: DIFF_W] = merged_diff[k];
    end
  end

  // Per-slot best tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < N_CHAR; k++) begin
        best_idx[k]  <= '1;
        best_diff[k] <= '1;
      end
    end else if (do_init) begin
      for (int unsigned k = 0; k < N_CHAR; k++) begin
        best_idx[k]  <= '1;
        best_diff[k] <= '1;
      end
    end else if (state == ACCUM) begin
      for (int unsigned k = 0; k < N_CHAR; k++) begin
        best_idx[k]  <= merged_idx[k];
        best_diff[k] <= merged_diff[k];
      end
    end
  end

  // Result registers, valid pulse, frame counter, busy and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.char_index_c <= '0;
      bus.char_diff_c  <= '0;
      bus.char_valid_c <= 1'b0;
      bus.busy         <= 1'b0;
      bus.frame_cnt    <= '0;
      bus.proto_err    <= 1'b0;
    end else begin
      bus.char_valid_c <= emit_go;
      bus.busy         <= (state_nxt != IDLE);
      if (emit_go) begin
        bus.char_index_c <= packed_idx;
        bus.char_diff_c  <= packed_diff;
        bus.frame_cnt    <= bus.frame_cnt + 8'd1;
      end
      if (err_evt) bus.proto_err <= 1'b1;
    end
  end

endmodule
